// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    ACK    = 2'd3
  } arb_state_e;

  // Which requester currently owns the memory port
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle counter that flags a hung memory transaction.
module mem_arb_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;

  // Clear dominates; otherwise count every enabled cycle
  always_comb begin
    tmo_d = tmo_q;
    if (clr) begin
      tmo_d = '0;
    end else if (en) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign expired = (tmo_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch/data sharing with data priority,
// fetch starvation guard, variable-latency handshake and timeout abort.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_e        state_q,    state_d;
  arb_owner_e        owner_q,    owner_d;
  logic              m_req_q,    m_req_d;
  logic              m_we_q,     m_we_d;
  logic [ADDR_W-1:0] m_addr_q,   m_addr_d;
  logic [DATA_W-1:0] m_wdata_q,  m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q,  i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
  logic              i_ack_q,    i_ack_d;
  logic              d_ack_q,    d_ack_d;
  logic              err_q,      err_d;
  logic [SW-1:0]     d_streak_q, d_streak_d;

  logic              busy;
  logic              tmo_expired;
  logic              fetch_forced;
  logic [DATA_W-1:0] rdata_nxt;

  assign busy         = (state_q == BUSY_I) || (state_q == BUSY_D);
  // Fetch wins a tie only once data has used up its streak allowance
  assign fetch_forced = i_req && (d_streak_q == STREAK_MAX);

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (~busy),
    .en      (busy),
    .expired (tmo_expired)
  );

  // Next-state and next-output computation for the arbiter FSM
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    d_streak_d = d_streak_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    err_d      = 1'b0;
    rdata_nxt  = '0;

    case (state_q)
      IDLE: begin
        if (d_req && !fetch_forced) begin
          state_d   = BUSY_D;
          owner_d   = OWN_D;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          // Only grants that make a waiting fetch wait longer count
          if (i_req && (d_streak_q != STREAK_MAX)) begin
            d_streak_d = d_streak_q + 1'b1;
          end
        end else if (i_req) begin
          state_d    = BUSY_I;
          owner_d    = OWN_I;
          m_req_d    = 1'b1;
          m_we_d     = 1'b0;
          m_addr_d   = i_addr;
          m_wdata_d  = '0;
          d_streak_d = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        // m_ready wins over an expiry landing on the same cycle
        if (m_ready || tmo_expired) begin
          state_d   = ACK;
          m_req_d   = 1'b0;
          err_d     = ~m_ready;
          rdata_nxt = (m_ready && !m_we_q) ? m_rdata : '0;
          if (owner_q == OWN_D) begin
            d_rdata_d = rdata_nxt;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = rdata_nxt;
            i_ack_d   = 1'b1;
          end
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      err_q      <= 1'b0;
      d_streak_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
      err_q      <= err_d;
      d_streak_q <= d_streak_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a variable-latency memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          ack_cyc;
  } sb_t;

  sb_t         i_q[$];
  sb_t         d_q[$];
  bit          grants[$];
  logic [31:0] mem[logic [31:0]];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_lat  = 0;
  int mcnt     = 0;
  bit mem_hang = 0;
  bit m_req_prev = 0;

  mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .MAX_D_STREAK (4),
    .TIMEOUT      (64)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .err     (err),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ready (m_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Memory: answers L cycles after m_req is first seen, or never when hung
  always @(negedge clk) begin
    if (m_req) begin
      if (!mem_hang && mcnt == mem_lat) begin
        m_ready = 1'b1;
        if (m_we) begin
          mem[m_addr] = m_wdata;
          m_rdata = 32'hFFFF_FFFF;
        end else begin
          m_rdata = mem.exists(m_addr) ? mem[m_addr] : mem_init(m_addr);
        end
      end else begin
        m_ready = 1'b0;
        m_rdata = 32'h0BAD_0BAD;
      end
      mcnt++;
    end else begin
      m_ready = 1'b0;
      mcnt = 0;
    end
  end

  // Monitor: pop scoreboard on each ack, log grant order
  always @(negedge clk) begin
    sb_t e;
    if (!rst) begin
      if (i_ack && d_ack) check("dual_ack", 64'(1), 64'(0));
      if (i_ack) begin
        if (i_q.size() == 0) check("i_ack_unexpected", 64'(1), 64'(0));
        else begin
          e = i_q.pop_front();
          check("i_rdata", 64'(i_rdata), 64'(e.rdata));
          check("i_err", 64'(err), 64'(e.err));
          if (e.ack_cyc >= 0) check("i_ack_cycle", 64'(cyc), 64'(e.ack_cyc));
        end
      end
      if (d_ack) begin
        if (d_q.size() == 0) check("d_ack_unexpected", 64'(1), 64'(0));
        else begin
          e = d_q.pop_front();
          check("d_rdata", 64'(d_rdata), 64'(e.rdata));
          check("d_err", 64'(err), 64'(e.err));
          if (e.ack_cyc >= 0) check("d_ack_cycle", 64'(cyc), 64'(e.ack_cyc));
        end
      end
      if (err && !i_ack && !d_ack) check("err_stray", 64'(1), 64'(0));
      if (m_req && !m_req_prev) grants.push_back(m_addr[28]);
    end
    m_req_prev = m_req;
  end

  task automatic wait_ack(input bit is_d);
    int n;
    bit ack;
    n = 0;
    ack = is_d ? d_ack : i_ack;
    while (!ack && n < 300) begin
      @(negedge clk);
      n++;
      ack = is_d ? d_ack : i_ack;
    end
    if (!ack) check(is_d ? "d_ack_wait" : "i_ack_wait", 64'(0), 64'(1));
    else check("m_req_at_ack", 64'(m_req), 64'(0));
    if (is_d) d_req = 1'b0;
    else i_req = 1'b0;
  endtask

  // One transaction; lat >= 0 means uncontended with exact timing checks
  task automatic xact(input bit is_d, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input bit exp_err, input int lat);
    sb_t e;
    if (lat >= 0) @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    e.rdata   = exp_rd;
    e.err     = exp_err;
    e.ack_cyc = (lat >= 0) ? cyc + 2 + lat : -1;
    if (is_d) d_q.push_back(e);
    else i_q.push_back(e);
    @(negedge clk);
    if (lat >= 0) begin
      check("m_req_c1", 64'(m_req), 64'(1));
      check("m_addr_c1", 64'(m_addr), 64'(addr));
      check("m_we_c1", 64'(m_we), 64'(we));
      check("m_wdata_c1", 64'(m_wdata), is_d ? 64'(wdata) : 64'(0));
    end
    wait_ack(is_d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    m_rdata = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_req", 64'(m_req), 64'(0));
    check("rst_acks_err", 64'({i_ack, d_ack, err, m_we}), 64'(0));
    check("rst_m_addr_wdata", {m_addr, m_wdata}, 64'(0));
    check("rst_rdata", {i_rdata, d_rdata}, 64'(0));
    rst = 1'b0;

    // Fetch alone, L=0
    mem_lat = 0;
    mem[32'h0040_0000] = 32'h00A0_0093;
    xact(1'b0, 1'b0, 32'h0040_0000, 32'h0, 32'h00A0_0093, 1'b0, 0);

    // Data write then read, L=3
    mem_lat = 3;
    xact(1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 3);
    xact(1'b1, 1'b0, 32'h1001_0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);

    // Timeout: memory never answers
    mem_hang = 1'b1;
    xact(1'b1, 1'b0, 32'h1001_0040, 32'h0, 32'h0, 1'b1, 63);
    // Answer on the last BUSY cycle beats the timeout
    mem_hang = 1'b0;
    mem_lat = 63;
    xact(1'b1, 1'b0, 32'h1001_0044, 32'h0, mem_init(32'h1001_0044), 1'b0, 63);

    // Contention: both held continuously
    mem_lat = 1;
    repeat (2) @(negedge clk);
    grants.delete();
    fork
      begin
        for (int k = 0; k < 2; k++)
          xact(1'b0, 1'b0, 32'h0040_1000 + 32'(k * 4), 32'h0,
               mem_init(32'h0040_1000 + 32'(k * 4)), 1'b0, -1);
      end
      begin
        for (int k = 0; k < 8; k++)
          xact(1'b1, 1'b0, 32'h1001_0100 + 32'(k * 4), 32'h0,
               mem_init(32'h1001_0100 + 32'(k * 4)), 1'b0, -1);
      end
    join
    check("grant_count", 64'(grants.size()), 64'(10));
    for (int k = 0; k < 10; k++) begin
      if (k < grants.size())
        check($sformatf("grant_%0d_is_d", k), 64'(grants[k]), (k % 5 == 4) ? 64'(0) : 64'(1));
    end

    // Reset in the middle of an L=5 fetch
    mem_lat = 5;
    @(negedge clk);
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0040_0100;
    @(negedge clk);
    check("rstb_m_req_c1", 64'(m_req), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstb_m_req", 64'(m_req), 64'(0));
    check("rstb_acks_err", 64'({i_ack, d_ack, err, m_we}), 64'(0));
    check("rstb_m_addr_wdata", {m_addr, m_wdata}, 64'(0));
    check("rstb_rdata", {i_rdata, d_rdata}, 64'(0));
    rst = 1'b0;
    begin
      sb_t e;
      e.rdata = mem_init(32'h0040_0100);
      e.err = 1'b0;
      e.ack_cyc = cyc + 2 + 5;
      i_q.push_back(e);
    end
    wait_ack(1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(i_q.size() + d_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and sequencer sharing one unified memory between the processor's instruction-fetch and data-access paths. Accepts one request at a time from each requester, grants the memory port with fixed data priority and a starvation guard for fetch, drives a req/ready handshake to a variable-latency memory, and returns a one-cycle acknowledge with registered read data. A timeout counter terminates hung memory transactions with an error flag.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_D_STREAK`, 4, max consecutive data grants while a fetch is pending (≥1)
- `TIMEOUT`, 64, BUSY cycles without `m_ready` before abort (≥2)

- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `i_req` in 1: fetch request, held until `i_ack`
- `i_addr` in ADDR_W: fetch address, stable while `i_req`
- `i_rdata` out DATA_W: fetch read data, valid with `i_ack`
- `i_ack` out 1: one-cycle fetch completion
- `d_req` in 1: data request, held until `d_ack`
- `d_we` in 1: 1 = write, 0 = read
- `d_addr` in ADDR_W: data address
- `d_wdata` in DATA_W: write data
- `d_rdata` out DATA_W: data read data, valid with `d_ack`
- `d_ack` out 1: one-cycle data completion
- `err` out 1: valid with either ack; 1 = transaction timed out
- `m_req` out 1: memory request, registered
- `m_we` out 1: memory write enable
- `m_addr` out ADDR_W, `m_wdata` out DATA_W: latched at grant
- `m_rdata` in DATA_W: memory read data, valid with `m_ready`
- `m_ready` in 1: one-cycle memory completion

## Operation
- States: IDLE, BUSY_I, BUSY_D, ACK.
- IDLE: sample requests each cycle.
  - `d_req` only: go to BUSY_D.
  - `i_req` only: go to BUSY_I.
  - Both asserted: go to BUSY_D, unless `d_streak == MAX_D_STREAK`, then go to BUSY_I.
  - On grant: latch address, write data and we into the `m_*` registers, assert `m_req`, record the owner.
  - Fetch grants force `m_we=0`, `m_wdata=0`.
- `d_streak` counter:
  - Increments on a data grant made while `i_req` is high.
  - Clears on any fetch grant.
  - Saturates at MAX_D_STREAK.
- BUSY_x:
  - Hold `m_req=1` and hold `m_addr`/`m_we`/`m_wdata` stable.
  - `tmo` counter increments each cycle.
  - On `m_ready`: capture `m_rdata` into the owner's rdata register, or 0 if a write; `err=0`; drop `m_req`; go to ACK.
  - If `tmo == TIMEOUT-1` without `m_ready`: drop `m_req`, rdata=0, `err=1`, go to ACK.
  - `m_ready` is ignored outside BUSY.
- ACK:
  - Owner's ack=1 for exactly one cycle; then go to IDLE.
  - Requests are not sampled in ACK.
  - Requester drops req on the ack cycle, so the following IDLE sees the next real request.
- Non-owner rdata registers hold their last value. `err` is 0 except in ACK.
- Reset from any state: state IDLE; `m_req`, `m_we`, `i_ack`, `d_ack`, `err` = 0; `m_addr`, `m_wdata`, `i_rdata`, `d_rdata` = 0; `d_streak`, `tmo` = 0.
- Reset mid-BUSY drops `m_req` at the reset edge; the aborted transaction is never acked.

## Timing
- Cycle 0: request seen in IDLE. Cycle 1: BUSY, `m_req=1`.
- `m_ready` may assert in cycle 1 or later, at cycle 1+L.
- Ack at cycle 2+L. Minimum request-to-ack latency is 2 cycles.
- Back-to-back throughput: one transaction per L+3 cycles (IDLE, BUSY×(L+1), ACK).
- Timeout ack occurs at cycle TIMEOUT+1 after the request cycle.
- Simultaneous events:
  - `m_ready` on the timeout cycle: `m_ready` wins, `err=0`.
  - A new request arriving during BUSY/ACK waits and is arbitrated on the next IDLE.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE, BUSY_I, BUSY_D, ACK)
  - owner encoding (OWN_I, OWN_D)
  - default ADDR_W/DATA_W constants
- Sub-module `mem_arb_timer`: `tmo` counter with clear/enable and expiry output. Everything else stays in one module.

## Test plan
- Fetch alone: `i_req`, `i_addr=0x00400000`, memory returns 0x00A00093 with L=0 → `m_req` at cycle 1, `i_ack` at cycle 2, `i_rdata=0x00A00093`, `err=0`.
- Data write then read: `d_we=1`, `d_addr=0x10010000`, `d_wdata=0xDEADBEEF`, L=3 → `m_we=1`, `d_ack` at cycle 5 with `d_rdata=0`. Then a read with L=3 → `d_rdata=0xDEADBEEF`.
- Contention: `i_req` and `d_req` both held continuously, MAX_D_STREAK=4 → grant order D,D,D,D,I,D,D,D,D,I…, with no fetch starvation.
- Timeout: `d_req` with `m_ready` never asserted, TIMEOUT=64 → `m_req` drops at cycle 65, `d_ack=1`, `err=1`, `d_rdata=0`. `m_ready` on the 64th BUSY cycle instead → `err=0`.
- Reset mid-BUSY: assert `rst` at cycle 2 of an L=5 read → at the next edge `m_req=0`, all outputs 0, state IDLE, no ack. After release, the held `i_req` completes normally.
